// File: rtl/sr_flipflop.sv
// sr_flipflop: WIDTH independent clocked SR storage bits with complementary
// output and a registered per-bit flag for cycles where set and reset collide.
module sr_flipflop #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 BOTH_MODE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] both_err
);

  logic [WIDTH-1:0] q_p0;
  logic [WIDTH-1:0] err_p0;
  logic [WIDTH-1:0] q_nxt;

  // Next state of every bit; a set/reset collision resolves per BOTH_MODE,
  // and any unknown mode encoding falls back to hold.
  function automatic logic [WIDTH-1:0] sr_next(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] set_i,
    input logic [WIDTH-1:0] clr_i
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({set_i[i], clr_i[i]})
        2'b00: nxt[i] = cur[i];
        2'b01: nxt[i] = 1'b0;
        2'b10: nxt[i] = 1'b1;
        default: begin
          case (BOTH_MODE)
            1:       nxt[i] = 1'b1;
            2:       nxt[i] = 1'b0;
            3:       nxt[i] = ~cur[i];
            default: nxt[i] = cur[i];
          endcase
        end
      endcase
    end
    return nxt;
  endfunction

  // Combinational next-state evaluation from the sampled requests.
  always_comb begin
    q_nxt = sr_next(q_p0, s, r);
  end

  // Stage p0: state and collision flag registers; async reset overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0   <= RESET_VALUE;
      err_p0 <= '0;
    end else begin
      q_p0   <= q_nxt;
      err_p0 <= s & r;
    end
  end

  assign q        = q_p0;
  assign qn       = ~q_p0;
  assign both_err = err_p0;

endmodule

// File: tb/tb_sr_flipflop.sv
// tb_sr_flipflop: directed checks of sr_flipflop across collision modes and a
// 4-bit instance with a non-zero reset value.
module tb_sr_flipflop;

  logic       clk;
  logic       run;
  logic       rst_n;
  logic [0:0] s1, r1;
  logic [3:0] s4, r4;

  // index 0..4 -> BOTH_MODE 0, 1, 2, 3, 7 (out-of-range, behaves as hold)
  logic [0:0] q   [5];
  logic [0:0] qn  [5];
  logic [0:0] be  [5];
  logic [3:0] q4, qn4, be4;

  int total;
  int bad;

  sr_flipflop #(.WIDTH(1), .BOTH_MODE(0)) u_m0 (.clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q[0]), .qn(qn[0]), .both_err(be[0]));
  sr_flipflop #(.WIDTH(1), .BOTH_MODE(1)) u_m1 (.clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q[1]), .qn(qn[1]), .both_err(be[1]));
  sr_flipflop #(.WIDTH(1), .BOTH_MODE(2)) u_m2 (.clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q[2]), .qn(qn[2]), .both_err(be[2]));
  sr_flipflop #(.WIDTH(1), .BOTH_MODE(3)) u_m3 (.clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q[3]), .qn(qn[3]), .both_err(be[3]));
  sr_flipflop #(.WIDTH(1), .BOTH_MODE(7)) u_m7 (.clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q[4]), .qn(qn[4]), .both_err(be[4]));
  sr_flipflop #(.WIDTH(4), .RESET_VALUE(4'b1010), .BOTH_MODE(0)) u_w4 (.clk(clk),
    .rst_n(rst_n), .s(s4), .r(r4), .q(q4), .qn(qn4), .both_err(be4));

  // 200 ns period clock that can be parked low
  initial clk = 1'b0;
  always begin
    #100;
    if (run) clk = ~clk;
    else     clk = 1'b0;
  end

  // Drive at the falling edge, then sample 1 ns after the next rising edge.
  task automatic edge1(input logic sv, input logic rv);
    @(negedge clk);
    s1 = sv;
    r1 = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s1 = 1'b1; r1 = 1'b0; s4 = 4'b1111; r4 = 4'b0000;
    #5 rst_n = 1'b0;
    #5;
    total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL reset_q got=%b want=0", q[0]); end
    total++; if (qn[0] !== 1'b1) begin bad++; $display("FAIL reset_qn got=%b want=1", qn[0]); end
    total++; if (be[0] !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", be[0]); end
    total++; if (q4 !== 4'b1010) begin bad++; $display("FAIL reset_q4 got=%b want=1010", q4); end
    total++; if (qn4 !== 4'b0101) begin bad++; $display("FAIL reset_qn4 got=%b want=0101", qn4); end
    #20 rst_n = 1'b1;
    s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000;
    run = 1'b1;
    @(posedge clk); #1;
    total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL release_q got=%b want=0", q[0]); end
    total++; if (q4 !== 4'b1010) begin bad++; $display("FAIL release_q4 got=%b want=1010", q4); end
  endtask

  task automatic test_sequence();
    edge1(1'b0, 1'b0);
    total++; if (q[0] !== 1'b0 || qn[0] !== 1'b1) begin bad++; $display("FAIL seq_hold got=%b/%b want=0/1", q[0], qn[0]); end
    edge1(1'b0, 1'b1);
    total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL seq_reset got=%b want=0", q[0]); end
    edge1(1'b1, 1'b0);
    total++; if (q[0] !== 1'b1 || qn[0] !== 1'b0) begin bad++; $display("FAIL seq_set got=%b/%b want=1/0", q[0], qn[0]); end
    edge1(1'b1, 1'b1);
    total++; if (q[0] !== 1'b1) begin bad++; $display("FAIL seq_both_q got=%b want=1", q[0]); end
    total++; if (be[0] !== 1'b1) begin bad++; $display("FAIL seq_both_err got=%b want=1", be[0]); end
    total++; if (q[4] !== 1'b1 || be[4] !== 1'b1) begin bad++; $display("FAIL seq_mode7 got=%b/%b want=1/1", q[4], be[4]); end
    edge1(1'b0, 1'b0);
    total++; if (be[0] !== 1'b0 || q[0] !== 1'b1) begin bad++; $display("FAIL seq_err_clear got=%b/%b want=1/0", q[0], be[0]); end
  endtask

  task automatic test_inter_edge();
    edge1(1'b0, 1'b1);
    total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL ie_clear got=%b want=0", q[0]); end
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
    @(posedge clk);
    #20 s1 = 1'b1;
    #20 s1 = 1'b0;
    @(posedge clk); #1;
    total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL ie_glitch got=%b want=0", q[0]); end
  endtask

  task automatic test_both_mode();
    edge1(1'b1, 1'b0);
    total++; if (q[1] !== 1'b1 || q[2] !== 1'b1 || q[3] !== 1'b1) begin bad++; $display("FAIL bm_preset got=%b%b%b want=111", q[1], q[2], q[3]); end
    edge1(1'b1, 1'b1);
    total++; if (q[1] !== 1'b1) begin bad++; $display("FAIL bm_m1_e1 got=%b want=1", q[1]); end
    total++; if (q[2] !== 1'b0) begin bad++; $display("FAIL bm_m2_e1 got=%b want=0", q[2]); end
    total++; if (q[3] !== 1'b0) begin bad++; $display("FAIL bm_m3_e1 got=%b want=0", q[3]); end
    edge1(1'b1, 1'b1);
    total++; if (q[1] !== 1'b1) begin bad++; $display("FAIL bm_m1_e2 got=%b want=1", q[1]); end
    total++; if (q[2] !== 1'b0) begin bad++; $display("FAIL bm_m2_e2 got=%b want=0", q[2]); end
    total++; if (q[3] !== 1'b1) begin bad++; $display("FAIL bm_m3_e2 got=%b want=1", q[3]); end
    total++; if (q[0] !== 1'b1 || q[4] !== 1'b1) begin bad++; $display("FAIL bm_hold got=%b%b want=11", q[0], q[4]); end
    edge1(1'b0, 1'b0);
  endtask

  task automatic test_multibit();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (q4 !== 4'b1010) begin bad++; $display("FAIL mb_reset got=%b want=1010", q4); end
    @(negedge clk);
    rst_n = 1'b1;
    s4 = 4'b0101; r4 = 4'b1000;
    @(posedge clk); #1;
    total++; if (q4 !== 4'b0111 || be4 !== 4'b0000) begin bad++; $display("FAIL mb_mix got=%b/%b want=0111/0000", q4, be4); end
    @(negedge clk);
    s4 = 4'b0001; r4 = 4'b0001;
    @(posedge clk); #1;
    total++; if (q4 !== 4'b0111 || be4 !== 4'b0001) begin bad++; $display("FAIL mb_both got=%b/%b want=0111/0001", q4, be4); end
    total++; if (qn4 !== 4'b1000) begin bad++; $display("FAIL mb_qn got=%b want=1000", qn4); end
    @(negedge clk);
    s4 = 4'b0000; r4 = 4'b0000;
    @(posedge clk); #1;
    total++; if (be4 !== 4'b0000) begin bad++; $display("FAIL mb_err_clear got=%b want=0000", be4); end
  endtask

  task automatic test_async_mid();
    edge1(1'b1, 1'b0);
    total++; if (q[0] !== 1'b1) begin bad++; $display("FAIL am_set got=%b want=1", q[0]); end
    #30 rst_n = 1'b0;
    #1;
    total++; if (q[0] !== 1'b0 || qn[0] !== 1'b1) begin bad++; $display("FAIL am_now got=%b/%b want=0/1", q[0], qn[0]); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      total++; if (q[0] !== 1'b0) begin bad++; $display("FAIL am_hold%0d got=%b want=0", k, q[0]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (q[0] !== 1'b1) begin bad++; $display("FAIL am_release got=%b want=1", q[0]); end
  endtask

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    run   = 1'b0;
    rst_n = 1'b1;
    s1 = 1'b0; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    test_reset();
    test_sequence();
    test_inter_edge();
    test_both_mode();
    test_multibit();
    test_async_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
